// File: rtl/wbm_led_seq_pkg.sv
// rtl/wbm_led_seq_pkg.sv - State encodings and LED-sweep slave field layout for wbm_led_seq
package wbm_led_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WR_REQ = 3'd1,
      ST_WR_ACK = 3'd2,
      ST_GAP    = 3'd3,
      ST_RD_REQ = 3'd4,
      ST_RD_ACK = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   // Slave status word: {4'h0, index[3:0], led[7:0]}
   localparam int STAT_IDX_MSB = 11;
   localparam int STAT_IDX_LSB = 8;
   localparam int STAT_LED_MSB = 7;
   localparam int STAT_LED_LSB = 0;

   localparam logic [15:0] LED_START_WORD = 16'h0001;
   localparam logic [15:0] LED_SLAVE_ADDR = 16'h0000;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// rtl/wb_ack_timer.sv - Saturating strobe-to-ack cycle counter with expiry flag
// Used by wbm_led_seq only when WBM_LED_SEQ_TIMEOUT_EN is defined.
module wb_ack_timer #(
   parameter int LIMIT = 255
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_load,
   input  logic i_inc,
   output logic o_expire
);

   localparam logic [7:0] LAST = 8'(LIMIT - 1);

   logic [7:0] cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_load) begin
         cnt <= 8'd0;
      end else if (i_inc && cnt != LAST) begin
         cnt <= cnt + 8'd1;
      end
   end

   // Expiry in the LIMIT-th active cycle, so the bus drops on the following edge
   assign o_expire = i_inc && (cnt == LAST);

endmodule

// File: rtl/wbm_led_seq.sv
// rtl/wbm_led_seq.sv - Pipelined Wishbone master running N LED sweeps with status polling
// Optional bus timeout abort: define WBM_LED_SEQ_TIMEOUT_EN.
module wbm_led_seq
   import wbm_led_seq_pkg::*;
#(
   parameter int AW       = 16,
   parameter int DW       = 16,
   parameter int POLL_GAP = 4,
   parameter int TIMEOUT  = 255
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_start,
   input  logic [7:0]    i_count,
   output logic          o_cyc,
   output logic          o_stb,
   output logic          o_we,
   output logic [AW-1:0] o_addr,
   output logic [DW-1:0] o_data,
   input  logic          i_stall,
   input  logic          i_ack,
   input  logic [DW-1:0] i_data,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_err,
   output logic [7:0]    o_sweeps,
   output logic [DW-1:0] o_status
);

   localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

   state_t        state;
   state_t        state_nxt;
   logic          wr_hold;
   logic [GW-1:0] gap_cnt;
   logic          gap_last;
   logic [7:0]    remaining;
   logic          zero_done;
   logic [3:0]    rd_index;
   logic          ack_tmo;
   logic          tmo_abort;

   assign gap_last  = (gap_cnt == GW'(POLL_GAP - 1));
   assign rd_index  = i_data[STAT_IDX_MSB:STAT_IDX_LSB];
   // A timeout coinciding with the ack still completes the transfer
   assign tmo_abort = ack_tmo && !(((state == ST_WR_ACK) || (state == ST_RD_ACK)) && i_ack);
   assign o_addr    = AW'(LED_SLAVE_ADDR);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (i_start && i_count != 8'd0) state_nxt = ST_WR_REQ;
         end
         ST_WR_REQ: begin
            if (tmo_abort)                 state_nxt = ST_IDLE;
            else if (!wr_hold && !i_stall) state_nxt = ST_WR_ACK;
         end
         ST_WR_ACK: begin
            if (i_ack)          state_nxt = ST_GAP;
            else if (tmo_abort) state_nxt = ST_IDLE;
         end
         ST_GAP: begin
            if (gap_last) state_nxt = ST_RD_REQ;
         end
         ST_RD_REQ: begin
            if (tmo_abort)     state_nxt = ST_IDLE;
            else if (!i_stall) state_nxt = ST_RD_ACK;
         end
         ST_RD_ACK: begin
            if (i_ack) begin
               if (rd_index != 4'd0)      state_nxt = ST_GAP;
               else if (remaining <= 8'd1) state_nxt = ST_DONE;
               else                       state_nxt = ST_WR_REQ;
            end else if (tmo_abort) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_cyc  = 1'b0;
      o_stb  = 1'b0;
      o_we   = 1'b0;
      o_data = '0;
      o_busy = 1'b1;
      case (state)
         ST_IDLE: o_busy = 1'b0;
         ST_WR_REQ: begin
            // wr_hold keeps cyc low for one cycle between back-to-back sweeps
            o_cyc  = !wr_hold;
            o_stb  = !wr_hold;
            o_we   = !wr_hold;
            o_data = DW'(LED_START_WORD);
         end
         ST_WR_ACK: begin
            o_cyc = 1'b1;
            o_we  = 1'b1;
         end
         ST_RD_REQ: begin
            o_cyc = 1'b1;
            o_stb = 1'b1;
         end
         ST_RD_ACK: o_cyc = 1'b1;
         default: ;
      endcase
   end

   assign o_done = (state == ST_DONE) || zero_done;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_hold   <= 1'b0;
         gap_cnt   <= '0;
         remaining <= 8'd0;
         o_sweeps  <= 8'd0;
         o_status  <= '0;
         zero_done <= 1'b0;
      end else begin
         zero_done <= (state == ST_IDLE) && i_start && (i_count == 8'd0);
         wr_hold   <= (state == ST_RD_ACK) && (state_nxt == ST_WR_REQ);
         gap_cnt   <= (state == ST_GAP && !gap_last) ? gap_cnt + GW'(1) : '0;
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  remaining <= i_count;
                  o_sweeps  <= 8'd0;
               end
            end
            ST_RD_ACK: begin
               if (i_ack) begin
                  o_status <= i_data;
                  if (rd_index == 4'd0) begin
                     o_sweeps <= sat_inc8(o_sweeps);
                     if (remaining > 8'd1) remaining <= remaining - 8'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef WBM_LED_SEQ_TIMEOUT_EN
   logic bus_active;
   logic err_q;

   assign bus_active = !wr_hold && ((state == ST_WR_REQ) || (state == ST_WR_ACK) ||
                                    (state == ST_RD_REQ) || (state == ST_RD_ACK));

   wb_ack_timer #(
      .LIMIT(TIMEOUT)
   ) u_ack_timer (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (!bus_active),
      .i_inc   (bus_active),
      .o_expire(ack_tmo)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         err_q <= 1'b0;
      end else if (state == ST_IDLE && i_start) begin
         err_q <= 1'b0;
      end else if (tmo_abort) begin
         err_q <= 1'b1;
      end
   end

   assign o_err = err_q;
`else
   assign ack_tmo = 1'b0;
   assign o_err   = 1'b0;
`endif

endmodule
